// File: rtl/br_wb_arbiter.sv
// Writeback arbiter: ALU and load results share the register bank write port.
// Optional busy scoreboard enabled by defining BR_WB_SCOREBOARD_EN.
module br_wb_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [DW-1:0]    alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_rd,
  input  logic [DW-1:0]    mem_data,
  output logic             br_we,
  output logic [AW-1:0]    br_a3,
  output logic [DW-1:0]    br_wd3,
  output logic [CNT_W-1:0] conflict_cnt,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    q_a1,
  input  logic [AW-1:0]    q_a2,
  output logic             busy1,
  output logic             busy2
);

  typedef enum logic {
    GR_ALU = 1'b0,
    GR_MEM = 1'b1
  } grant_e;

  grant_e          last_q;
  logic            gnt_alu;
  logic            gnt_mem;
  logic            xfer;
  logic [AW-1:0]   w_rd;
  logic [DW-1:0]   w_data;
  logic            w_en;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    unique case (1'b1)
      (alu_valid & ~mem_valid): gnt_alu = 1'b1;
      (~alu_valid & mem_valid): gnt_mem = 1'b1;
      (alu_valid & mem_valid): begin
        gnt_alu = (last_q == GR_MEM);
        gnt_mem = (last_q == GR_ALU);
      end
      default: ;
    endcase
  end

  // Ready is forced low while reset is held.
  assign alu_ready = gnt_alu & rst_n;
  assign mem_ready = gnt_mem & rst_n;
  assign xfer      = alu_ready | mem_ready;
  assign w_rd      = alu_ready ? alu_rd : mem_rd;
  assign w_data    = alu_ready ? alu_data : mem_data;
  assign w_en      = xfer && (w_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= GR_MEM;
      br_we        <= 1'b0;
      br_a3        <= '0;
      br_wd3       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (xfer) begin
        last_q <= alu_ready ? GR_ALU : GR_MEM;
      end
      br_we <= w_en;
      if (w_en) begin
        br_a3  <= w_rd;
        br_wd3 <= w_data;
      end
      if (alu_valid && mem_valid && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

`ifdef BR_WB_SCOREBOARD_EN
  localparam int NR = 2 ** AW;

  logic [NR-1:0] busy_q;
  logic [NR-1:0] set_v;
  logic [NR-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_valid && (iss_rd != '0)) begin
      set_v[iss_rd] = 1'b1;
    end
    if (w_en) begin
      clr_v[w_rd] = 1'b1;
    end
  end

  // Set after clear: a re-issue in the retire cycle keeps the reg pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_v) | set_v;
    end
  end

  assign busy1 = busy_q[q_a1];
  assign busy2 = busy_q[q_a2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, q_a1, q_a2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule
